// File: rtl/m_mc_core_if.sv
// Bus bundle for m_mc_core: instruction-memory fetch port plus write-back trace and status.
interface m_mc_core_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] w_imem_addr;
    logic [31:0]        w_imem_data;
    logic [XLEN-1:0]    w_pc;
    logic               w_halted;
    logic               w_retire;
    logic               w_wb_en;
    logic [4:0]         w_wb_addr;
    logic [XLEN-1:0]    w_wb_data;

    modport master (
        output w_imem_addr, w_pc, w_halted, w_retire, w_wb_en, w_wb_addr, w_wb_data,
        input  w_imem_data
    );

    modport slave (
        input  w_imem_addr, w_pc, w_halted, w_retire, w_wb_en, w_wb_addr, w_wb_data,
        output w_imem_data
    );
endinterface

// File: rtl/m_mc_core.sv
// Four-state multi-cycle integer core (ADDI/ADD/SUB) with halt-on-write to HALT_REG.
// Define M_MC_CORE_BRANCH_EN to add BEQ/BNE; otherwise opcode 1100011 retires as a NOP.
module m_mc_core #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int IMEM_AW  = 6,
    parameter int HALT_REG = 30
) (
    input  logic       w_clk,
    input  logic       w_rst,
    m_mc_core_if.master bus
);
    localparam int RAW = $clog2(NREG);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t                 state;
    logic [XLEN-1:0]        r_pc;
    logic [31:0]            r_ir;
    logic [XLEN-1:0]        r_alu;
    logic [XLEN-1:0]        rf [NREG];
    logic                   retire;
    logic                   wb_en;
    logic [4:0]             wb_addr;
    logic                   halted;

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [4:0]             rs1, rs2, rd;
    logic signed [XLEN-1:0] op_a, op_b, imm_i, alu_res;
    logic                   writes;
    logic [XLEN-1:0]        pc_step;

    function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

    assign opcode = r_ir[6:0];
    assign funct3 = r_ir[14:12];
    assign rd     = r_ir[11:7];
    assign rs1    = r_ir[19:15];
    assign rs2    = r_ir[24:20];
    assign imm_i  = sext12(r_ir[31:20]);

    // Indices beyond the implemented register count read as zero.
    assign op_a = (32'(rs1) < NREG) ? rf[rs1[RAW-1:0]] : '0;
    assign op_b = (32'(rs2) < NREG) ? rf[rs2[RAW-1:0]] : '0;

    always_comb begin
        alu_res = '0;
        writes  = 1'b0;
        if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            alu_res = op_a + imm_i;
            writes  = 1'b1;
        end else if (opcode == 7'b0110011 && funct3 == 3'b000) begin
            alu_res = r_ir[30] ? (op_a - op_b) : (op_a + op_b);
            writes  = 1'b1;
        end
    end

`ifdef M_MC_CORE_BRANCH_EN
    logic r_br_taken;

    function automatic logic signed [XLEN-1:0] sext13(input logic [12:0] v);
        return {{(XLEN-13){v[12]}}, v};
    endfunction

    assign pc_step = r_br_taken
                   ? sext13({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0})
                   : XLEN'(4);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_br_taken <= 1'b0;
        end else if (state == S_EXEC) begin
            r_br_taken <= (opcode == 7'b1100011) &&
                          ((funct3 == 3'b000 && op_a == op_b) ||
                           (funct3 == 3'b001 && op_a != op_b));
        end
    end
`else
    assign pc_step = XLEN'(4);
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state   <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_alu   <= '0;
            retire  <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            halted  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    r_ir  <= bus.w_imem_data;
                    state <= S_EXEC;
                end
                // Trace outputs are registered here so they are valid throughout WB.
                S_EXEC: begin
                    r_alu   <= alu_res;
                    retire  <= 1'b1;
                    wb_en   <= writes && (rd != 5'd0) && (32'(rd) < NREG);
                    wb_addr <= rd;
                    state   <= S_WB;
                end
                S_WB: begin
                    if (wb_en) rf[wb_addr[RAW-1:0]] <= r_alu;
                    r_pc   <= r_pc + pc_step;
                    retire <= 1'b0;
                    wb_en  <= 1'b0;
                    if (wb_en && 32'(wb_addr) == HALT_REG) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign bus.w_imem_addr = r_pc[IMEM_AW+1:2];
    assign bus.w_pc        = r_pc;
    assign bus.w_halted    = halted;
    assign bus.w_retire    = retire;
    assign bus.w_wb_en     = wb_en;
    assign bus.w_wb_addr   = wb_addr;
    assign bus.w_wb_data   = r_alu;
endmodule

// File: tb/tb_m_mc_core.sv
// Directed bench for m_mc_core: table-driven program traces plus reset, overflow and branch sequences.
module tb_m_mc_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_mc_core_if #(.XLEN(32), .IMEM_AW(6)) bus ();

    m_mc_core #(.XLEN(32), .NREG(32), .IMEM_AW(6), .HALT_REG(30)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus.master)
    );

    logic [31:0] mem [64];
    always @(posedge clk) bus.w_imem_data <= mem[bus.w_imem_addr];

    typedef struct {
        logic [31:0] inst;
        logic        wb_en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cur  = 0;

`ifdef M_MC_CORE_BRANCH_EN
    localparam logic [31:0] BEQ_PC   = 32'd16;
    localparam logic [4:0]  BEQ_NEXT = 5'd6;
`else
    localparam logic [31:0] BEQ_PC   = 32'd12;
    localparam logic [4:0]  BEQ_NEXT = 5'd5;
`endif

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic sub, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {1'b0, sub, 5'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] inst, input logic en, input logic [4:0] addr,
                                input logic [31:0] data, input logic [31:0] pc);
        vec_t v;
        v.inst = inst; v.wb_en = en; v.addr = addr; v.data = data; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cur < n) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    // Hold reset, check the reset values, release so that the current cycle is cycle 1.
    task automatic start();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst pc",      bus.w_pc, 32'd0);
        chk("rst halted",  32'(bus.w_halted), 32'd0);
        chk("rst retire",  32'(bus.w_retire), 32'd0);
        chk("rst wb_en",   32'(bus.w_wb_en), 32'd0);
        chk("rst wb_addr", 32'(bus.w_wb_addr), 32'd0);
        chk("rst wb_data", bus.w_wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cur = 1;
    endtask

    task automatic wb_chk(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data, input logic [31:0] pc);
        chk({tag, " retire"}, 32'(bus.w_retire), 32'd1);
        chk({tag, " wb_en"},  32'(bus.w_wb_en), 32'(en));
        chk({tag, " wb_addr"}, 32'(bus.w_wb_addr), 32'(addr));
        if (en) chk({tag, " wb_data"}, bus.w_wb_data, data);
        chk({tag, " pc"}, bus.w_pc, pc);
    endtask

    task automatic run_table(input string tag);
        int n;
        clear_mem();
        n = tbl.size();
        for (int k = 0; k < n; k++) mem[k] = tbl[k].inst;
        start();
        for (int k = 0; k < n; k++) begin
            goto(4 * k + 4);
            wb_chk($sformatf("%s k%0d", tag, k), tbl[k].wb_en, tbl[k].addr, tbl[k].data, tbl[k].pc);
            goto(4 * k + 5);
            chk($sformatf("%s k%0d retire_low", tag, k), 32'(bus.w_retire), 32'd0);
        end
        chk({tag, " halted"}, 32'(bus.w_halted), 32'd1);
        chk({tag, " halt pc"}, bus.w_pc, 32'(4 * n));
        goto(4 * n + 8);
        chk({tag, " still halted"}, 32'(bus.w_halted), 32'd1);
        chk({tag, " frozen pc"}, bus.w_pc, 32'(4 * n));
        chk({tag, " halt retire"}, 32'(bus.w_retire), 32'd0);
        chk({tag, " halt wb_en"}, 32'(bus.w_wb_en), 32'd0);
    endtask

    initial begin
        clear_mem();

        // Basic arithmetic program ending in a write to x30.
        tbl.delete();
        tbl.push_back(mk(enc_i(5'd1, 5'd0, 12'd5),     1'b1, 5'd1,  32'd5,         32'd0));
        tbl.push_back(mk(enc_i(5'd2, 5'd0, 12'hFFD),   1'b1, 5'd2,  32'hFFFFFFFD,  32'd4));
        tbl.push_back(mk(enc_r(1'b0, 5'd3, 5'd1, 5'd2), 1'b1, 5'd3, 32'd2,         32'd8));
        tbl.push_back(mk(enc_r(1'b1, 5'd4, 5'd1, 5'd2), 1'b1, 5'd4, 32'd8,         32'd12));
        tbl.push_back(mk(enc_i(5'd30, 5'd0, 12'd1),    1'b1, 5'd30, 32'd1,         32'd16));
        run_table("arith");

        // x0 writes are suppressed; a zero-valued write to x30 still halts.
        tbl.delete();
        tbl.push_back(mk(enc_i(5'd0, 5'd0, 12'd7),     1'b0, 5'd0,  32'd0, 32'd0));
        tbl.push_back(mk(enc_r(1'b0, 5'd5, 5'd0, 5'd0), 1'b1, 5'd5, 32'd0, 32'd4));
        tbl.push_back(mk(enc_i(5'd30, 5'd0, 12'd0),    1'b1, 5'd30, 32'd0, 32'd8));
        run_table("x0");

        // Undefined opcode retires without a write and advances the PC.
        tbl.delete();
        tbl.push_back(mk(32'h0000007F,                 1'b0, 5'd0,  32'd0, 32'd0));
        tbl.push_back(mk(enc_i(5'd30, 5'd0, 12'd1),    1'b1, 5'd30, 32'd1, 32'd4));
        run_table("undef");

        // Wrap-around: doubling to 2^31, then 0x7FFFFFFF + 1 and 0 - 1.
        clear_mem();
        mem[0] = enc_i(5'd1, 5'd0, 12'd1);
        for (int j = 1; j <= 31; j++) mem[j] = enc_r(1'b0, 5'd1, 5'd1, 5'd1);
        mem[32] = enc_i(5'd1, 5'd1, 12'hFFF);
        mem[33] = enc_i(5'd1, 5'd1, 12'd1);
        mem[34] = enc_i(5'd2, 5'd0, 12'd1);
        mem[35] = enc_r(1'b1, 5'd3, 5'd0, 5'd2);
        mem[36] = enc_i(5'd30, 5'd0, 12'd2);
        start();
        goto(128); wb_chk("ovf 2^31", 1'b1, 5'd1, 32'h80000000, 32'd124);
        goto(132); wb_chk("ovf max",  1'b1, 5'd1, 32'h7FFFFFFF, 32'd128);
        goto(136); wb_chk("ovf wrap", 1'b1, 5'd1, 32'h80000000, 32'd132);
        goto(144); wb_chk("ovf neg",  1'b1, 5'd3, 32'hFFFFFFFF, 32'd140);
        goto(148); wb_chk("ovf halt", 1'b1, 5'd30, 32'd2, 32'd144);
        goto(149);
        chk("ovf halted", 32'(bus.w_halted), 32'd1);
        chk("ovf halt pc", bus.w_pc, 32'd148);

        // Reset during EXEC of instruction 2 aborts it and clears the register file.
        clear_mem();
        mem[0] = enc_i(5'd1, 5'd0, 12'd5);
        mem[1] = enc_i(5'd2, 5'd0, 12'd6);
        mem[2] = enc_i(5'd3, 5'd0, 12'd7);
        mem[3] = enc_i(5'd4, 5'd0, 12'd8);
        mem[4] = enc_i(5'd30, 5'd0, 12'd1);
        start();
        goto(4); wb_chk("mid k0", 1'b1, 5'd1, 32'd5, 32'd0);
        goto(8); wb_chk("mid k1", 1'b1, 5'd2, 32'd6, 32'd4);
        goto(11);
        rst = 1'b1;
        clear_mem();
        mem[0] = enc_r(1'b0, 5'd5, 5'd1, 5'd2);
        mem[1] = enc_r(1'b0, 5'd6, 5'd3, 5'd4);
        mem[2] = enc_i(5'd7, 5'd1, 12'd0);
        mem[3] = enc_i(5'd30, 5'd0, 12'd9);
        @(posedge clk);
        #1;
        chk("mid abort retire", 32'(bus.w_retire), 32'd0);
        chk("mid abort wb_en", 32'(bus.w_wb_en), 32'd0);
        chk("mid abort pc", bus.w_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cur = 1;
        goto(3);
        chk("mid no early retire", 32'(bus.w_retire), 32'd0);
        goto(4);  wb_chk("post k0", 1'b1, 5'd5, 32'd0, 32'd0);
        goto(8);  wb_chk("post k1", 1'b1, 5'd6, 32'd0, 32'd4);
        goto(12); wb_chk("post k2", 1'b1, 5'd7, 32'd0, 32'd8);
        goto(16); wb_chk("post k3", 1'b1, 5'd30, 32'd9, 32'd12);
        goto(17);
        chk("post halted", 32'(bus.w_halted), 32'd1);

        // BEQ/BNE at pc 8 with equal operands.
        for (int b = 0; b < 2; b++) begin
            clear_mem();
            mem[0] = enc_i(5'd1, 5'd0, 12'd3);
            mem[1] = enc_i(5'd2, 5'd0, 12'd3);
            mem[2] = enc_b((b == 0) ? 3'b000 : 3'b001, 5'd1, 5'd2, 13'd8);
            mem[3] = enc_i(5'd5, 5'd0, 12'd1);
            mem[4] = enc_i(5'd6, 5'd0, 12'd2);
            mem[5] = enc_i(5'd30, 5'd0, 12'd1);
            start();
            goto(12);
            wb_chk($sformatf("br%0d wb", b), 1'b0, 5'd8, 32'd0, 32'd8);
            goto(13);
            chk($sformatf("br%0d next pc", b), bus.w_pc, (b == 0) ? BEQ_PC : 32'd12);
            goto(16);
            chk($sformatf("br%0d next rd", b), 32'(bus.w_wb_addr), (b == 0) ? 32'(BEQ_NEXT) : 32'd5);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
